product_accumulator: RTL
========================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 combinational multiplier.
- Consumes the 16-bit product stream under valid/ready and accumulates one vector of products into a saturating accumulator. Vectors are delimited by in_last.
- Emits one dot-product result per vector through a single-entry registered output with valid/ready.
- Used for FIR taps and dot-product datapaths fed by the multiplier.

Parameters:
- PROD_W, 16, width of incoming product.
- ACC_W, 24, accumulator/result width; must be > PROD_W.
- MAX_LEN, 256, maximum elements per vector; must be a power of two, 2..256.
- CNT_W, $clog2(MAX_LEN)+1, width of element count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  stage can accept a beat.
- in_product  in  PROD_W  unsigned product from the multiplier.
- in_last  in  1  beat is the final element of the current vector.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  accumulated sum, saturated.
- out_count  out  CNT_W  number of elements in the vector (1..MAX_LEN).
- out_ovf  out  1  saturation occurred within this vector.
- out_trunc  out  1  vector forcibly closed at MAX_LEN without in_last.

Behaviour:
- Clock/reset: single clock clk. Reset rst is synchronous and active-high. All state updates occur on the rising clk edge.
- Reset clears the accumulator, count and state (IDLE).
- Reset values: out_valid=0, out_sum=0, out_count=0, out_ovf=0, out_trunc=0.
- in_ready is combinational: in_ready = !out_valid || out_ready. It does not depend on in_valid.
- Accept = in_valid && in_ready.
- State machine:
  - IDLE: acc=0, cnt=0.
  - ACCUM: at least one element has been accumulated.
  - IDLE->ACCUM on an accepted non-closing beat. ACCUM->IDLE on an accepted closing beat.
- Closing beat: in_last=1, or cnt==MAX_LEN-1 (the latter sets trunc=1).
- Non-closing accept:
  - acc <= sat(acc + in_product); cnt <= cnt+1.
  - The sticky ovf flag sets if the sum exceeded 2^ACC_W-1.
- Closing accept:
  - out_sum <= sat(acc + in_product); out_count <= cnt+1.
  - out_ovf <= ovf | this-beat overflow; out_trunc <= trunc.
  - out_valid <= 1. acc, cnt and ovf clear to 0 and the FSM returns to IDLE.
- Latency: the result is visible the cycle after the closing beat is accepted.
- Saturation: the sum is computed at ACC_W+1 bits; if the MSB is set, the result is clamped to all-ones. Once saturated, the accumulator stays at all-ones for the rest of the vector.
- Output hold: out_valid && !out_ready holds all out_* stable and keeps in_ready=0. No beats are accepted, so the accumulator is frozen.
- out_ready && out_valid with no closing accept: out_valid <= 0 next cycle.
- Simultaneous output pop and closing accept in the same cycle: the new result loads and out_valid stays 1. Full throughput, one result per cycle for length-1 vectors.
- in_product=0 is a legal beat and counts as an element.
- Reset mid-vector: the partial sum is discarded and no result is emitted.

Decomposition:
- Package product_accumulator_pkg holds:
  - Default constants ACC_W_DEF=24 and MAX_LEN_DEF=256.
  - Typedef acc_t (logic [ACC_W-1:0]).
  - Enum state_e {IDLE, ACCUM}.
- One sub-module, sat_add:
  - Purely combinational, parameterised on width.
  - Computes a + zero-extended b, returning the saturated sum and an overflow bit.
  - Reusable by other accumulating stages.

Test Plan:
- 4 beats of 65025 (255x255), last on beat 4, out_ready=1: out_sum=260100 one cycle after beat 4, out_count=4, out_ovf=0, out_trunc=0.
- Length-1 vectors back-to-back (products 3, 5, 7, all in_last), out_ready=1: results 3, 5, 7 on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: vector {10,20} completes with out_ready=0, then a new vector {1} is offered: in_ready=0, out_sum held at 30 until out_ready=1; next result is 1.
- ACC_W=18: 5 beats of 65025 -> out_sum=262143, out_ovf=1; the following vector {2,2} gives out_sum=4, out_ovf=0.
- MAX_LEN=4: 6 beats of 1, no in_last until beat 6: first result out_sum=4, out_count=4, out_trunc=1; second result out_sum=2, out_count=2, out_trunc=0.
- rst asserted after 2 of 3 beats {100,100,100}, then vector {9}: no result for the partial vector; the next result is out_sum=9, out_count=1.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared constants and types for the product accumulator stage.
package product_accumulator_pkg;

    localparam int unsigned PROD_W_DEF  = 16;
    localparam int unsigned ACC_W_DEF   = 24;
    localparam int unsigned MAX_LEN_DEF = 256;

    typedef logic [ACC_W_DEF-1:0] acc_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder: a + zero-extended b, clamped to all-ones.
module sat_add #(
    parameter int unsigned A_W = 24,
    parameter int unsigned B_W = 16
) (
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    output logic [A_W-1:0] sum_c_o,
    output logic           ovf_c_o
);

    logic [A_W:0] wide_sum;

    // One extra bit catches the carry out of the accumulator width.
    assign wide_sum = {1'b0, a_i} + (A_W+1)'(b_i);
    assign ovf_c_o  = wide_sum[A_W];
    assign sum_c_o  = wide_sum[A_W] ? {A_W{1'b1}} : wide_sum[A_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a vector of multiplier products into a saturating sum and
// emits one result per vector through a single-entry registered output.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W  = PROD_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned CNT_W   = $clog2(MAX_LEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_trunc
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_trunc_q, out_trunc_d;

    logic [ACC_W-1:0]   beat_sum;
    logic               beat_ovf;
    logic               accept;
    logic               at_limit;
    logic               closing;

    sat_add #(
        .A_W (ACC_W),
        .B_W (PROD_W)
    ) u_sat_add (
        .a_i     (acc_q),
        .b_i     (in_product),
        .sum_c_o (beat_sum),
        .ovf_c_o (beat_ovf)
    );

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign at_limit = (cnt_q == CNT_W'(MAX_LEN - 1));
    assign closing  = in_last || at_limit;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_trunc_d = out_trunc_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (closing) begin
                out_valid_d = 1'b1;
                out_sum_d   = beat_sum;
                out_count_d = cnt_q + CNT_W'(1);
                out_ovf_d   = ovf_q | beat_ovf;
                out_trunc_d = !in_last;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                state_d     = IDLE;
            end else begin
                acc_d   = beat_sum;
                cnt_d   = cnt_q + CNT_W'(1);
                ovf_d   = ovf_q | beat_ovf;
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
    assign out_trunc = out_trunc_q;

endmodule
